imem_window: RTL and testbench



---
 rtl/imem_pkg.sv | 29 ++
 rtl/imem_wbuf.sv | 54 +++++
 rtl/imem_window.sv | 144 ++++++++++++++
 tb/tb_imem_window.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory window responder.
// Holds the word width, FSM state encoding and the window-extract function.
package imem_pkg;

    localparam int unsigned IMEM_WORD_W = 64;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StResp
    } imem_state_e;

    // Pick the 64-bit window starting at halfword 'off' of the {word[w], word[w1]} pair.
    function automatic logic [IMEM_WORD_W-1:0] window_extract(
        input logic [2*IMEM_WORD_W-1:0] pair,
        input logic [1:0]               off
    );
        logic [IMEM_WORD_W-1:0] win;
        case (off)
            2'd0:    win = pair[127:64];
            2'd1:    win = pair[111:48];
            2'd2:    win = pair[95:32];
            default: win = pair[79:16];
        endcase
        return win;
    endfunction

endpackage

// File: rtl/imem_wbuf.sv
// Two-slot word buffer, direct-mapped on the word-index LSB.
// Looks up w and w1 in parallel; one write port and a bulk clear of the valid bits.
module imem_wbuf
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clr,
    input  logic                   i_we,
    input  logic [ADDR_W-1:0]      i_waddr,
    input  logic [IMEM_WORD_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]      i_w,
    input  logic [ADDR_W-1:0]      i_w1,
    output logic                   o_hit_w,
    output logic                   o_hit_w1,
    output logic [IMEM_WORD_W-1:0] o_data_w,
    output logic [IMEM_WORD_W-1:0] o_data_w1
);

    logic [1:0]             r_vld;
    logic [ADDR_W-1:0]      r_tag  [2];
    logic [IMEM_WORD_W-1:0] r_data [2];

    // Clear wins over a same-cycle write so an invalidate is never lost.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_vld <= '0;
        end else begin
            if (i_we) begin
                r_vld[i_waddr[0]] <= 1'b1;
            end
            if (i_clr) begin
                r_vld <= '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_tag[i_waddr[0]]  <= i_waddr;
            r_data[i_waddr[0]] <= i_wdata;
        end
    end

    always_comb begin
        o_hit_w   = r_vld[i_w[0]] && (r_tag[i_w[0]] == i_w);
        o_hit_w1  = r_vld[i_w1[0]] && (r_tag[i_w1[0]] == i_w1);
        o_data_w  = r_data[i_w[0]];
        o_data_w1 = r_data[i_w1[0]];
    end

endmodule

// File: rtl/imem_window.sv
// Instruction-memory responder: returns a 64-bit window at any halfword address,
// served from a 2-word buffer and filled from a 1-cycle-latency SRAM on a miss.
module imem_window
    import imem_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [63:0]            i_imem_addr,
    input  logic                   i_imem_addr_valid,
    output logic [IMEM_WORD_W-1:0] o_imem_data,
    output logic                   o_imem_data_valid,
    input  logic                   i_inval,
    output logic                   o_sram_en,
    output logic [ADDR_W-1:0]      o_sram_addr,
    input  logic [IMEM_WORD_W-1:0] i_sram_rdata
);

    imem_state_e            r_state, w_state_d;
    logic [ADDR_W-1:0]      r_w, r_w1, r_sram_addr;
    logic [1:0]             r_off;
    logic                   r_pend_inval, w_pend_inval_d;
    logic [IMEM_WORD_W-1:0] r_data;
    logic                   r_data_valid;

    logic [ADDR_W-1:0]      w_in_w, w_in_w1, w_lk_w, w_lk_w1, w_req_addr;
    logic [1:0]             w_in_off, w_lk_off;
    logic                   w_hit_w, w_hit_w1, w_all_hit;
    logic [IMEM_WORD_W-1:0] w_data_w, w_data_w1, w_window;
    logic                   w_clr, w_we, w_load, w_latch;
    logic                   w_unused_addr;

    assign w_in_w        = i_imem_addr[ADDR_W+2:3];
    assign w_in_w1       = w_in_w + ADDR_W'(1);
    assign w_in_off      = i_imem_addr[2:1];
    assign w_unused_addr = ^{i_imem_addr[63:ADDR_W+3], i_imem_addr[0]};

    // In IDLE the lookup follows the live request; otherwise the latched one.
    assign w_lk_w   = (r_state == StIdle) ? w_in_w   : r_w;
    assign w_lk_w1  = (r_state == StIdle) ? w_in_w1  : r_w1;
    assign w_lk_off = (r_state == StIdle) ? w_in_off : r_off;

    imem_wbuf #(
        .ADDR_W (ADDR_W)
    ) u_wbuf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (w_clr),
        .i_we      (w_we),
        .i_waddr   (r_sram_addr),
        .i_wdata   (i_sram_rdata),
        .i_w       (w_lk_w),
        .i_w1      (w_lk_w1),
        .o_hit_w   (w_hit_w),
        .o_hit_w1  (w_hit_w1),
        .o_data_w  (w_data_w),
        .o_data_w1 (w_data_w1)
    );

    assign w_all_hit  = w_hit_w && (w_hit_w1 || (w_lk_off == 2'd0));
    assign w_window   = window_extract({w_data_w, w_data_w1}, w_lk_off);
    assign w_req_addr = w_hit_w ? r_w1 : r_w;

    assign o_sram_en         = (r_state == StReq);
    assign o_sram_addr       = (r_state == StReq) ? w_req_addr : r_sram_addr;
    assign o_imem_data       = r_data;
    assign o_imem_data_valid = r_data_valid;

    always_comb begin
        w_state_d      = r_state;
        w_pend_inval_d = r_pend_inval;
        w_clr          = 1'b0;
        w_we           = 1'b0;
        w_load         = 1'b0;
        w_latch        = 1'b0;
        case (r_state)
            StIdle: begin
                w_clr          = i_inval;
                w_pend_inval_d = 1'b0;
                if (i_imem_addr_valid) begin
                    w_latch = 1'b1;
                    if (w_all_hit && !i_inval) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_d = StReq;
                    end
                end
            end
            StReq: begin
                w_pend_inval_d = r_pend_inval | i_inval;
                w_state_d      = StWait;
            end
            StWait: begin
                w_we           = 1'b1;
                w_pend_inval_d = r_pend_inval | i_inval;
                // Slots differ for w and w1, so this write cannot change the w1 hit.
                if ((r_sram_addr == r_w) && (r_off != 2'd0) && !w_hit_w1) begin
                    w_state_d = StReq;
                end else begin
                    w_state_d = StResp;
                end
            end
            StResp: begin
                w_load         = 1'b1;
                w_clr          = r_pend_inval | i_inval;
                w_pend_inval_d = 1'b0;
                w_state_d      = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= StIdle;
            r_pend_inval <= 1'b0;
            r_sram_addr  <= '0;
            r_data       <= '0;
            r_data_valid <= 1'b0;
            r_w          <= '0;
            r_w1         <= '0;
            r_off        <= '0;
        end else begin
            r_state      <= w_state_d;
            r_pend_inval <= w_pend_inval_d;
            r_data_valid <= w_load;
            if (w_load) begin
                r_data <= w_window;
            end
            if (r_state == StReq) begin
                r_sram_addr <= w_req_addr;
            end
            if (w_latch) begin
                r_w   <= w_in_w;
                r_w1  <= w_in_w1;
                r_off <= w_in_off;
            end
        end
    end

endmodule

// File: tb/tb_imem_window.sv
// Randomized bench for imem_window: two instances (ADDR_W=12 and ADDR_W=3) see the same
// requests and are compared against a per-instance buffer/window reference model.
module tb_imem_window;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] req_addr;
    logic        req_valid;
    logic        inval;

    logic [63:0] a_data, a_rdata, b_data, b_rdata;
    logic        a_dv, a_en, b_dv, b_en;
    logic [11:0] a_saddr;
    logic [2:0]  b_saddr;

    logic [63:0] mem_a [4096];
    logic [63:0] mem_b [8];

    imem_window #(.ADDR_W(12)) u_dut_a (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_imem_addr       (req_addr),
        .i_imem_addr_valid (req_valid),
        .o_imem_data       (a_data),
        .o_imem_data_valid (a_dv),
        .i_inval           (inval),
        .o_sram_en         (a_en),
        .o_sram_addr       (a_saddr),
        .i_sram_rdata      (a_rdata)
    );

    imem_window #(.ADDR_W(3)) u_dut_b (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_imem_addr       (req_addr),
        .i_imem_addr_valid (req_valid),
        .o_imem_data       (b_data),
        .o_imem_data_valid (b_dv),
        .i_inval           (inval),
        .o_sram_en         (b_en),
        .o_sram_addr       (b_saddr),
        .i_sram_rdata      (b_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (a_en) a_rdata <= mem_a[a_saddr];
        if (b_en) b_rdata <= mem_b[b_saddr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-instance observation of one transaction window.
    int          mon_nv   [2];
    int          mon_vcyc [2];
    logic [63:0] mon_vdata[2];
    int          mon_nrd  [2];
    int          mon_rd   [2][8];

    always @(negedge clk) begin
        if (a_dv) begin mon_nv[0]++; mon_vcyc[0] = cyc; mon_vdata[0] = a_data; end
        if (b_dv) begin mon_nv[1]++; mon_vcyc[1] = cyc; mon_vdata[1] = b_data; end
        if (a_en) begin
            if (mon_nrd[0] < 8) mon_rd[0][mon_nrd[0]] = int'(a_saddr);
            mon_nrd[0]++;
        end
        if (b_en) begin
            if (mon_nrd[1] < 8) mon_rd[1][mon_nrd[1]] = int'(b_saddr);
            mon_nrd[1]++;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: which word each slot holds, per instance.
    int unsigned aw    [2] = '{12, 3};
    bit          m_vld [2][2];
    int unsigned m_tag [2][2];

    function automatic logic [63:0] memw(input int d, input int unsigned i);
        logic [11:0] ia = 12'(i);
        logic [2:0]  ib = 3'(i);
        return (d == 0) ? mem_a[ia] : mem_b[ib];
    endfunction

    function automatic bit present(input int d, input int unsigned x);
        return m_vld[d][x % 2] && (m_tag[d][x % 2] == x);
    endfunction

    task automatic model_check(input int d, input logic [63:0] addr, input int req_cyc,
                               input bit inv_now, input bit inv_late, input bit rst_late);
        int unsigned mask = (32'd1 << aw[d]) - 1;
        int unsigned w    = int'(addr[34:3]) & mask;
        int unsigned w1   = (w + 1) & mask;
        int          off  = int'(addr[2:1]);
        int unsigned miss[$];
        logic [127:0] pair;
        logic [63:0]  exp_data;
        int           exp_nv, exp_nrd, exp_lat;
        string        pfx = (d == 0) ? "a12" : "b3";

        if (inv_now) begin m_vld[d][0] = 0; m_vld[d][1] = 0; end
        if (!present(d, w)) miss.push_back(w);
        if (off != 0 && !present(d, w1)) miss.push_back(w1);

        pair     = {memw(d, w), memw(d, w1)};
        exp_data = 64'(pair >> (64 - 16 * off));
        exp_lat  = (miss.size() == 0) ? 1 : 2 + 2 * miss.size();
        if (rst_late && miss.size() > 0) begin
            exp_nv  = 0;
            exp_nrd = 1;
        end else begin
            exp_nv  = 1;
            exp_nrd = miss.size();
        end

        foreach (miss[i]) begin
            m_vld[d][miss[i] % 2] = 1;
            m_tag[d][miss[i] % 2] = miss[i];
        end
        if (inv_late || rst_late) begin m_vld[d][0] = 0; m_vld[d][1] = 0; end

        check_eq({pfx, "_nvalid"}, 64'(mon_nv[d]), 64'(exp_nv));
        if (exp_nv == 1 && mon_nv[d] == 1) begin
            check_eq({pfx, "_latency"}, 64'(mon_vcyc[d] - req_cyc + 1), 64'(exp_lat));
            check_eq({pfx, "_data"}, mon_vdata[d], exp_data);
        end
        check_eq({pfx, "_nreads"}, 64'(mon_nrd[d]), 64'(exp_nrd));
        for (int i = 0; i < exp_nrd && i < mon_nrd[d] && i < 8; i++) begin
            check_eq({pfx, "_rdaddr"}, 64'(mon_rd[d][i]), 64'(miss[i]));
        end
    endtask

    task automatic run_req(input logic [63:0] addr, input bit inv_now,
                           input bit inv_late, input bit rst_late);
        int req_cyc;
        @(negedge clk);
        req_addr  = addr;
        req_valid = 1'b1;
        inval     = inv_now;
        #1;
        for (int d = 0; d < 2; d++) begin
            mon_nv[d]  = 0;
            mon_nrd[d] = 0;
        end
        @(negedge clk);
        req_cyc   = cyc;
        req_valid = 1'b0;
        inval     = 1'b0;
        req_addr  = {$urandom, $urandom};
        @(negedge clk);
        inval = inv_late;
        rst_n = !rst_late;
        @(negedge clk);
        inval = 1'b0;
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        model_check(0, addr, req_cyc, inv_now, inv_late, rst_late);
        model_check(1, addr, req_cyc, inv_now, inv_late, rst_late);
    endtask

    initial begin
        logic [63:0] addr;
        int unsigned idx;
        int unsigned pick;

        foreach (mem_a[i]) mem_a[i] = {$urandom, $urandom};
        foreach (mem_b[i]) mem_b[i] = {$urandom, $urandom};
        mem_a[0] = 64'h0011223344556677;
        mem_a[1] = 64'h8899AABBCCDDEEFF;
        mem_b[0] = 64'h0011223344556677;
        mem_b[1] = 64'h8899AABBCCDDEEFF;
        mem_b[7] = 64'hFEDCBA9876543210;
        for (int d = 0; d < 2; d++) begin
            m_vld[d][0] = 0;
            m_vld[d][1] = 0;
            m_tag[d][0] = 0;
            m_tag[d][1] = 0;
        end

        rst_n     = 1'b0;
        req_addr  = '0;
        req_valid = 1'b0;
        inval     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_a_data", a_data, 64'h0);
        check_eq("rst_a_dv", 64'(a_dv), 64'h0);
        check_eq("rst_a_en", 64'(a_en), 64'h0);
        check_eq("rst_a_saddr", 64'(a_saddr), 64'h0);
        check_eq("rst_b_data", b_data, 64'h0);
        check_eq("rst_b_dv", 64'(b_dv), 64'h0);
        check_eq("rst_b_en", 64'(b_en), 64'h0);

        run_req(64'h0, 0, 0, 0);   // cold: one read
        run_req(64'h0, 0, 0, 0);   // warm hit
        run_req(64'h2, 0, 0, 0);   // only word 1 missing
        run_req(64'h6, 0, 0, 0);   // both warm
        run_req(64'h4, 1, 0, 0);   // invalidated: two reads
        run_req(64'h0, 1, 0, 0);   // invalidate with warm buffer
        run_req(64'h8, 0, 1, 0);   // invalidate during WAIT
        run_req(64'h8, 0, 0, 0);   // must miss again
        run_req(64'h3E, 1, 0, 0);  // top-word wrap on the 3-bit instance
        run_req(64'h0, 1, 0, 1);   // reset during WAIT
        run_req(64'h0, 0, 0, 0);   // miss after reset

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            idx  = (pick == 9) ? 32'd4095 : pick % 6;
            addr = {$urandom, $urandom};
            addr[14:3] = 12'(idx);
            run_req(addr, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 19) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
